// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline control bundle between the LC-3b pipe datapath and hazard_stall_ctrl.
// Carries the cache handshakes, the ID/EX register-hazard fields and the redirect pulse.
// It also carries the stall/bubble/flush qualifiers, the debug state and the counters.
//   master : pipeline side, drives requests and hazard fields, observes qualifiers
//   slave  : controller side, observes requests, drives qualifiers and counters
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  localparam int unsigned REG_W = 3;

  logic                 imem_read;
  logic                 imem_resp;
  logic                 dmem_read;
  logic                 dmem_write;
  logic                 dmem_resp;
  logic [REG_W-1:0]     id_sr1;
  logic [REG_W-1:0]     id_sr2;
  logic                 id_uses_sr1;
  logic                 id_uses_sr2;
  logic [REG_W-1:0]     ex_dest;
  logic                 ex_is_load;
  logic                 ex_regwrite;
  logic                 redirect;

  logic                 stall_pipeline;
  logic                 stall_if_id;
  logic                 bubble_id_ex;
  logic                 flush_if_id;
  logic                 flush_id_ex;
  logic                 flush_ex_mem;
  logic [1:0]           state_out;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] bubble_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
           id_sr1, id_sr2, id_uses_sr1, id_uses_sr2,
           ex_dest, ex_is_load, ex_regwrite, redirect,
    input  stall_pipeline, stall_if_id, bubble_id_ex,
           flush_if_id, flush_id_ex, flush_ex_mem,
           state_out, stall_cycles, bubble_count, flush_count
  );

  modport slave (
    input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
           id_sr1, id_sr2, id_uses_sr1, id_uses_sr2,
           ex_dest, ex_is_load, ex_regwrite, redirect,
    output stall_pipeline, stall_if_id, bubble_id_ex,
           flush_if_id, flush_id_ex, flush_ex_mem,
           state_out, stall_cycles, bubble_count, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central stall/bubble/flush controller for the 5-stage LC-3b pipe.
// It holds a taken redirect across memory stalls and keeps saturating performance counters.
//   clk   : clock
//   reset : synchronous, active-high; forces all outputs to 0 while asserted
//   bus   : hazard_stall_ctrl_if.slave (cache handshakes, hazard fields, qualifiers, counters)
// Qualifiers are combinational from the current state and the inputs.
// Priority is memory stall, then flush, then load-use bubble.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_FLUSH_PEND = 2'd2,
    ST_ILLEGAL    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic                 w_mem_busy;
  logic                 w_sr1_hit;
  logic                 w_sr2_hit;
  logic                 w_lu_hazard;

  logic                 w_stall_pipeline;
  logic                 w_stall_if_id;
  logic                 w_bubble;
  logic                 w_flush;

  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_bubble_count;
  logic [CNT_WIDTH-1:0] r_flush_count;

  // Saturating +1
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
    sat_inc = (val == {CNT_WIDTH{1'b1}}) ? val : val + CNT_WIDTH'(1);
  endfunction

  // Outstanding cache request with no response this cycle
  assign w_mem_busy = (bus.imem_read & ~bus.imem_resp) |
                      ((bus.dmem_read | bus.dmem_write) & ~bus.dmem_resp);

  // Plain 3-bit compares; R0 is a real hazard target
  assign w_sr1_hit   = bus.id_uses_sr1 & (bus.id_sr1 == bus.ex_dest);
  assign w_sr2_hit   = bus.id_uses_sr2 & (bus.id_sr2 == bus.ex_dest);
  assign w_lu_hazard = bus.ex_is_load & bus.ex_regwrite & (w_sr1_hit | w_sr2_hit);

  // State register; the pending flush lives in ST_FLUSH_PEND, so reset drops it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and qualifier decode
  always_comb begin
    w_next_state     = r_state;
    w_stall_pipeline = 1'b0;
    w_stall_if_id    = 1'b0;
    w_bubble         = 1'b0;
    w_flush          = 1'b0;

    if (!reset) begin
      unique case (r_state)
        // MEM_WAIT falls back to RUN rules in its first free cycle, so both share a decode
        ST_RUN, ST_MEM_WAIT: begin
          w_stall_pipeline = w_mem_busy;
          if (w_mem_busy) begin
            w_next_state = bus.redirect ? ST_FLUSH_PEND : ST_MEM_WAIT;
          end else begin
            w_next_state = ST_RUN;
            if (bus.redirect) begin
              w_flush = 1'b1;
            end else if (w_lu_hazard) begin
              w_stall_if_id = 1'b1;
              w_bubble      = 1'b1;
            end
          end
        end
        // Redirect pulses while waiting merge into the one pending flush
        ST_FLUSH_PEND: begin
          w_stall_pipeline = w_mem_busy;
          if (!w_mem_busy) begin
            w_flush      = 1'b1;
            w_next_state = ST_RUN;
          end
        end
        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  // Performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_bubble_count <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall_pipeline) r_stall_cycles <= sat_inc(r_stall_cycles);
      if (w_bubble)         r_bubble_count <= sat_inc(r_bubble_count);
      if (w_flush)          r_flush_count  <= sat_inc(r_flush_count);
    end
  end

  assign bus.stall_pipeline = w_stall_pipeline;
  assign bus.stall_if_id    = w_stall_if_id;
  assign bus.bubble_id_ex   = w_bubble;
  assign bus.flush_if_id    = w_flush;
  assign bus.flush_id_ex    = w_flush;
  assign bus.flush_ex_mem   = w_flush;
  assign bus.state_out      = reset ? 2'd0 : r_state;
  assign bus.stall_cycles   = reset ? '0 : r_stall_cycles;
  assign bus.bubble_count   = reset ? '0 : r_bubble_count;
  assign bus.flush_count    = reset ? '0 : r_flush_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl, using 4-bit counters so saturation is reachable.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_hazard_stall_ctrl;

  localparam int unsigned CNT_W = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  hazard_stall_ctrl_if #(.CNT_WIDTH(CNT_W)) u_if ();

  hazard_stall_ctrl #(.CNT_WIDTH(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_if.imem_read   = 1'b0;
    u_if.imem_resp   = 1'b0;
    u_if.dmem_read   = 1'b0;
    u_if.dmem_write  = 1'b0;
    u_if.dmem_resp   = 1'b0;
    u_if.id_sr1      = 3'd0;
    u_if.id_sr2      = 3'd0;
    u_if.id_uses_sr1 = 1'b0;
    u_if.id_uses_sr2 = 1'b0;
    u_if.ex_dest     = 3'd0;
    u_if.ex_is_load  = 1'b0;
    u_if.ex_regwrite = 1'b0;
    u_if.redirect    = 1'b0;
  endtask

  // Sample point after inputs settle: checks flushes and bubble/stall_if_id together
  task automatic check_ctrl(input string tag, input logic exp_flush, input logic exp_bubble);
    #1;
    check({tag, ".flush_if_id"},  u_if.flush_if_id,  exp_flush);
    check({tag, ".flush_id_ex"},  u_if.flush_id_ex,  exp_flush);
    check({tag, ".flush_ex_mem"}, u_if.flush_ex_mem, exp_flush);
    check({tag, ".bubble"},       u_if.bubble_id_ex, exp_bubble);
    check({tag, ".stall_if_id"},  u_if.stall_if_id,  exp_bubble);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    reset = 1'b1;
    u_if.imem_read = 1'b1;
    #1;
    // Outputs forced low while reset is high, even with a busy cache
    #1 check("rst.stall_pipeline", u_if.stall_pipeline, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("rst.state", u_if.state_out, 2'd0);
    check("rst.stall_cycles", u_if.stall_cycles, 0);
    check("rst.bubble_count", u_if.bubble_count, 0);
    check("rst.flush_count", u_if.flush_count, 0);
    check_ctrl("rst", 1'b0, 1'b0);

    // Load-use on sr1 = R3
    u_if.ex_is_load = 1'b1; u_if.ex_regwrite = 1'b1; u_if.ex_dest = 3'd3;
    u_if.id_uses_sr1 = 1'b1; u_if.id_sr1 = 3'd3;
    check_ctrl("lu1", 1'b0, 1'b1);
    check("lu1.stall_pipeline", u_if.stall_pipeline, 1'b0);
    tick();
    u_if.ex_is_load = 1'b0;
    check_ctrl("lu1_after", 1'b0, 1'b0);
    check("lu1.bubble_count", u_if.bubble_count, 1);

    // Matching register but sr1 not read: no hazard
    u_if.ex_is_load = 1'b1; u_if.id_uses_sr1 = 1'b0;
    check_ctrl("lu_nouse", 1'b0, 1'b0);
    // Load without regwrite: no hazard
    u_if.id_uses_sr1 = 1'b1; u_if.ex_regwrite = 1'b0;
    check_ctrl("lu_norw", 1'b0, 1'b0);
    // R0 via sr2 is a legal hazard
    idle();
    u_if.ex_is_load = 1'b1; u_if.ex_regwrite = 1'b1; u_if.ex_dest = 3'd0;
    u_if.id_uses_sr2 = 1'b1; u_if.id_sr2 = 3'd0; u_if.id_sr1 = 3'd5; u_if.id_uses_sr1 = 1'b1;
    check_ctrl("lu_r0", 1'b0, 1'b1);
    tick();
    idle();
    #1 check("lu_r0.bubble_count", u_if.bubble_count, 2);

    // I-cache miss: 4 busy cycles, then response
    for (int i = 0; i < 4; i++) begin
      u_if.imem_read = 1'b1; u_if.imem_resp = 1'b0;
      #1;
      check("imiss.stall", u_if.stall_pipeline, 1'b1);
      check("imiss.state", u_if.state_out, (i == 0) ? 2'd0 : 2'd1);
      tick();
    end
    u_if.imem_resp = 1'b1;
    #1;
    check("imiss_resp.stall", u_if.stall_pipeline, 1'b0);
    check("imiss_resp.state", u_if.state_out, 2'd1);
    tick();
    idle();
    #1;
    check("imiss_done.state", u_if.state_out, 2'd0);
    check("imiss_done.stall_cycles", u_if.stall_cycles, 4);

    // D-cache read, redirect at wait cycles 2 and 4, response at cycle 5 with a load-use present
    for (int c = 1; c <= 5; c++) begin
      u_if.dmem_read = 1'b1;
      u_if.dmem_resp = (c == 5);
      u_if.redirect  = (c == 2) || (c == 4);
      if (c == 5) begin
        u_if.ex_is_load = 1'b1; u_if.ex_regwrite = 1'b1; u_if.ex_dest = 3'd6;
        u_if.id_uses_sr1 = 1'b1; u_if.id_sr1 = 3'd6;
      end
      check_ctrl($sformatf("dred_c%0d", c), (c == 5), 1'b0);
      check($sformatf("dred_c%0d.stall", c), u_if.stall_pipeline, (c != 5));
      if (c >= 3) check($sformatf("dred_c%0d.state", c), u_if.state_out, 2'd2);
      tick();
    end
    idle();
    #1;
    check("dred.state", u_if.state_out, 2'd0);
    check("dred.flush_count", u_if.flush_count, 1);
    check("dred.bubble_count", u_if.bubble_count, 2);
    check("dred.stall_cycles", u_if.stall_cycles, 8);

    // Redirect and load-use together in a free RUN cycle
    u_if.redirect = 1'b1;
    u_if.ex_is_load = 1'b1; u_if.ex_regwrite = 1'b1; u_if.ex_dest = 3'd2;
    u_if.id_uses_sr2 = 1'b1; u_if.id_sr2 = 3'd2;
    check_ctrl("red_lu", 1'b1, 1'b0);
    tick();
    idle();
    #1;
    check("red_lu.flush_count", u_if.flush_count, 2);
    check("red_lu.bubble_count", u_if.bubble_count, 2);
    check("red_lu.state", u_if.state_out, 2'd0);

    // Reset with a flush pending
    u_if.dmem_write = 1'b1; u_if.redirect = 1'b1;
    check_ctrl("pend_set", 1'b0, 1'b0);
    tick();
    u_if.redirect = 1'b0;
    #1 check("pend.state", u_if.state_out, 2'd2);
    reset = 1'b1;
    #1;
    check("pend_rst.stall", u_if.stall_pipeline, 1'b0);
    check("pend_rst.state", u_if.state_out, 2'd0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst.state", u_if.state_out, 2'd0);
    check("post_rst.stall_cycles", u_if.stall_cycles, 0);
    check("post_rst.flush_count", u_if.flush_count, 0);
    check("post_rst.bubble_count", u_if.bubble_count, 0);
    check("post_rst.stall", u_if.stall_pipeline, 1'b1);
    tick();
    u_if.dmem_resp = 1'b1;
    check_ctrl("post_rst_free", 1'b0, 1'b0);
    tick();
    idle();
    #1;
    check("post_rst.flush_count2", u_if.flush_count, 0);
    check("post_rst.stall_cycles2", u_if.stall_cycles, 1);

    // Saturation: 20 more busy cycles on top of 1
    u_if.imem_read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 13) check("sat.mid", u_if.stall_cycles, 14);
      tick();
    end
    idle();
    #1;
    check("sat.stall_cycles", u_if.stall_cycles, 15);
    tick();
    #1 check("sat.hold", u_if.stall_cycles, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
